synth_spi_cfg: RTL and testbench
================================

# synth_spi_cfg

SPI-slave configuration controller for the synthesizer core. It receives 16-bit write frames from an external master on spi_clk, spi_mosi and spi_nss, and decodes each frame into an address and a data byte. It then updates a bank of 8-bit configuration registers that drive the tone, envelope and trigger logic of synth_top. Everything runs in the system clock domain: the SPI pins are oversampled through synchronizers, and no logic is clocked by spi_clk.

## Interface
Parameters:
- NREGS, 8: number of 8-bit configuration registers; legal values 1..128.
- RST_VAL, {NREGS*8{1'b0}}: reset contents of the register bank, flat, with register 0 in bits [7:0].

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous, active-low reset.
- spi_clk, input, 1: SPI clock from the pad; asynchronous to clk; mode 0.
- spi_mosi, input, 1: SPI data from the pad; asynchronous to clk.
- spi_nss, input, 1: SPI chip select from the pad; active low; asynchronous to clk.
- cfg, output, NREGS*8: flat register bank, with register i in bits [8i+7:8i].
- wr_strobe, output, 1: one-cycle pulse when a register is written.
- wr_addr, output, 7: address of the last write; valid while wr_strobe is high, and held afterwards.
- frame_err, output, 1: one-cycle pulse when a frame is aborted or addresses an invalid register.

## Operation
- Synchronizers:
  - spi_clk, spi_mosi and spi_nss each pass through a 2-FF synchronizer.
  - spi_clk has a third flop for edge detection.
  - A rising edge (rise) is detected when sync2 is 1 and sync3 is 0.
- Frame format:
  - 16 bits, MSB first, sampled on rising spi_clk edges.
  - Bit 15 is R/W: 1 means write; 0 is a read, which the block accepts and discards (there is no MISO).
  - Bits 14:8 are the address.
  - Bits 7:0 are the data.
- FSM states:
  - IDLE: waiting for a frame. Go to SHIFT when synchronized nss is 0; the bit counter clears to 0.
  - SHIFT: on each rise, shift the synchronized mosi into a 16-bit shift register at the LSB and increment the 5-bit counter.
    - When the counter reaches 16, go to COMMIT.
    - If nss returns to 1 while the counter is between 1 and 15, pulse frame_err and go to IDLE.
    - If nss returns to 1 with the counter at 0, go to IDLE silently.
  - COMMIT: one cycle.
    - If it is a write and address < NREGS: update cfg[addr] and wr_addr, and pulse wr_strobe.
    - If it is a write and address >= NREGS: pulse frame_err and leave cfg unchanged.
    - If it is a read: no effect.
    - Then go to DONE.
  - DONE: ignore all further rises; go to IDLE when nss is 1. Only one frame is accepted per nss assertion.
- If rise and an nss deassertion occur in the same cycle, the nss deassertion takes priority: the bit is not shifted.
- The shift register and counter are not cleared in IDLE, except that the counter is cleared on entry to SHIFT.
- Reset is asynchronous and can occur mid-frame. It forces:
  - FSM to IDLE;
  - cfg to RST_VAL;
  - wr_strobe, frame_err and wr_addr to 0;
  - synchronizer flops to spi_clk = 0, mosi = 0, nss = 1.
- After reset is released during an active nss, the partial frame is received as a new frame starting from the next rise. This is a permitted master error; no frame_err is produced unless the frame is aborted.

## Timing
- Requirements on the SPI master:
  - spi_clk high and low phases each of at least 4 clk periods.
  - spi_mosi stable from 2 clk periods before to 2 clk periods after each rising spi_clk.
  - nss high for at least 4 clk periods between frames.
- Write latency:
  - Let edge N be the first clk edge at which the spi_clk pad is sampled high for bit 0 (the 16th bit).
  - The shift register and counter update at edge N+2.
  - COMMIT is the cycle after N+2.
  - cfg, wr_addr and wr_strobe change at edge N+3.
  - wr_strobe is high for exactly one cycle.
- frame_err is asserted for the one cycle following the edge at which the abort or invalid address is detected.
- All outputs are registered; no output has a combinational path from any input.

## Test plan
- Reset values: hold rstn low → cfg equals RST_VAL, wr_strobe = 0, frame_err = 0, wr_addr = 0.
- Write register 3: with clk at 100 MHz and spi_clk at 10 MHz, send 0x83A5 → cfg[31:24] = 0xA5 and wr_addr = 3; wr_strobe is one cycle, exactly 3 clk edges after the 16th rise is first sampled; other registers are unchanged.
- Write outside the bank: send 0x8A11 with NREGS = 8 → frame_err pulses once, no wr_strobe, cfg unchanged.
- Aborted frame: send 9 bits of 0x8155 then raise nss → frame_err pulses once, cfg unchanged. A following complete frame 0x8155 → cfg[15:8] = 0x55.
- Extra bits and read frames:
  - Send 24 bits (0x8266 followed by 0xFF) in one nss assertion → only register 2 = 0x66; one wr_strobe; no frame_err.
  - Send 0x0277 → no change.
- Reset mid-frame: pulse rstn low after 8 bits of 0x84C3, then finish the frame and reassert nss → cfg back to RST_VAL; the next full frame 0x84C3 writes register 4 = 0xC3.

Source files
------------

// File: rtl/synth_spi_cfg.sv
// SPI-slave configuration controller: oversamples a mode-0 SPI write stream in the
// clk domain and commits 16-bit {wr, addr, data} frames into a bank of 8-bit registers.
module synth_spi_cfg #(
  parameter int unsigned          NREGS   = 8,
  parameter logic [NREGS*8-1:0]   RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  input  logic                 spi_nss,
  output logic [NREGS*8-1:0]   cfg,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic                 frame_err
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CFG_W   = NREGS * DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  logic [2:0]         sclk_sync_q;
  logic [1:0]         mosi_sync_q;
  logic [1:0]         nss_sync_q;

  state_e             state_q,     state_d;
  logic [FRAME_W-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [CFG_W-1:0]   cfg_q,       cfg_d;
  logic [ADDR_W-1:0]  wr_addr_q,   wr_addr_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic               frame_err_q, frame_err_d;

  logic               rise;
  logic               mosi_s;
  logic               nss_s;
  frame_t             frame;

  // Pad synchronizers; reset to an idle bus (clk low, nss high)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      nss_sync_q  <= 2'b11;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      nss_sync_q  <= {nss_sync_q[0], spi_nss};
    end
  end

  assign rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign mosi_s = mosi_sync_q[1];
  assign nss_s  = nss_sync_q[1];
  assign frame  = frame_t'(shreg_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      cfg_q       <= RST_VAL;
      wr_addr_q   <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      wr_addr_q   <= wr_addr_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next state; the 16th bit moves straight to COMMIT so the write lands one edge later
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    wr_addr_d   = wr_addr_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!nss_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // nss deassertion wins over a coincident rise
        if (nss_s) begin
          frame_err_d = (cnt_q != '0);
          state_d     = IDLE;
        end else if (rise) begin
          shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
          cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (frame.wr) begin
          if (32'(frame.addr) < NREGS) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (frame.addr == ADDR_W'(i)) begin
                cfg_d[i*DATA_W +: DATA_W] = frame.data;
              end
            end
            wr_addr_d   = frame.addr;
            wr_strobe_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (nss_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg       = cfg_q;
  assign wr_addr   = wr_addr_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_synth_spi_cfg.sv
// Bench for synth_spi_cfg: directed vector table, reset-mid-frame sequence and random
// frames, all checked against a register-array model of the frame rules.
module tb_synth_spi_cfg;

  localparam int unsigned       NR = 8;
  localparam logic [NR*8-1:0]   RV = 64'h0123_4567_89AB_CDEF;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            spi_clk = 1'b0;
  logic            spi_mosi = 1'b0;
  logic            spi_nss = 1'b1;
  logic [NR*8-1:0] cfg;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic            frame_err;

  synth_spi_cfg #(.NREGS(NR), .RST_VAL(RV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_nss   (spi_nss),
    .cfg       (cfg),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_seen = 0;
  int edge16 = 0;
  int strobe_edge = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  logic pad_prev = 1'b0;

  logic [7:0] m [NR];
  logic [6:0] m_addr;

  // Observe pads at each edge (edge of 16th sampled rise) and output pulses just after it
  always @(posedge clk) begin
    cyc++;
    if (spi_nss) rise_seen = 0;
    else if (spi_clk && !pad_prev) begin
      rise_seen++;
      if (rise_seen == 16) edge16 = cyc;
    end
    pad_prev = spi_clk;
    #1;
    if (wr_strobe) begin
      strobe_cnt++;
      strobe_edge = cyc;
    end
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = m[i];
    return f;
  endfunction

  task automatic model_reset();
    logic [NR*8-1:0] rv_v;
    rv_v = RV;
    for (int i = 0; i < NR; i++) m[i] = rv_v[i*8 +: 8];
    m_addr = 7'd0;
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
    #2;
  endtask

  task automatic frame_start();
    spi_nss = 1'b0;
    half();
  endtask

  task automatic send_bits(input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = word[31-i];
      half();
      spi_clk = 1'b1;
      half();
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_end();
    half();
    spi_nss = 1'b1;
    repeat (8) @(negedge clk);
    #2;
  endtask

  // One nss assertion carrying the top n bits of word; model applies the frame rules
  task automatic run_txn(input logic [31:0] word, input int n, output int ds, output int de);
    int s0 = strobe_cnt;
    int e0 = err_cnt;
    int exp_s = 0;
    int exp_e = 0;
    logic [15:0] fr;
    int a;
    frame_start();
    send_bits(word, n);
    frame_end();
    ds = strobe_cnt - s0;
    de = err_cnt - e0;
    fr = word[31:16];
    a = int'(fr[14:8]);
    if (n >= 16) begin
      if (fr[15]) begin
        if (a < NR) begin
          m[a] = fr[7:0];
          m_addr = fr[14:8];
          exp_s = 1;
        end else begin
          exp_e = 1;
        end
      end
    end else if (n > 0) begin
      exp_e = 1;
    end
    chk("cfg", 64'(cfg), 64'(model_flat()));
    chk("strobe_count", 64'(ds), 64'(exp_s));
    chk("err_count", 64'(de), 64'(exp_e));
    chk("wr_addr", 64'(wr_addr), 64'(m_addr));
    if (exp_s == 1) chk("strobe_latency", 64'(strobe_edge - edge16), 64'd3);
  endtask

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          reg_idx;
    logic [7:0]  reg_val;
    int          strobes;
    int          errs;
    logic [6:0]  addr;
  } vec_t;

  vec_t tv [6];

  initial begin
    int ds, de, e0, s0;
    logic [31:0] w;
    logic [6:0]  ra;
    int nb, sel;

    tv[0] = '{32'h83A5_0000, 16, 3, 8'hA5, 1, 0, 7'd3};
    tv[1] = '{32'h8A11_0000, 16, 3, 8'hA5, 0, 1, 7'd3};
    tv[2] = '{32'h8155_0000,  9, 1, 8'hCD, 0, 1, 7'd3};
    tv[3] = '{32'h8155_0000, 16, 1, 8'h55, 1, 0, 7'd1};
    tv[4] = '{32'h8266_FF00, 24, 2, 8'h66, 1, 0, 7'd2};
    tv[5] = '{32'h0277_0000, 16, 2, 8'h66, 0, 0, 7'd2};

    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_cfg", 64'(cfg), 64'(RV));
    chk("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    #2 rstn = 1'b1;
    repeat (4) @(negedge clk);
    #2;

    for (int i = 0; i < 6; i++) begin
      run_txn(tv[i].word, tv[i].nbits, ds, de);
      chk($sformatf("vec%0d_reg", i), 64'(cfg[tv[i].reg_idx*8 +: 8]), 64'(tv[i].reg_val));
      chk($sformatf("vec%0d_strobes", i), 64'(ds), 64'(tv[i].strobes));
      chk($sformatf("vec%0d_errs", i), 64'(de), 64'(tv[i].errs));
      chk($sformatf("vec%0d_addr", i), 64'(wr_addr), 64'(tv[i].addr));
    end

    // Reset in the middle of a frame, then the tail of that frame as an aborted frame
    s0 = strobe_cnt;
    frame_start();
    send_bits(32'h84C3_0000, 8);
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midrst_cfg", 64'(cfg), 64'(RV));
    chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst_strobe", 64'(wr_strobe), 64'd0);
    chk("midrst_err", 64'(frame_err), 64'd0);
    #2 rstn = 1'b1;
    e0 = err_cnt;
    send_bits(32'hC300_0000, 8);
    frame_end();
    chk("midrst_tail_err", 64'(err_cnt - e0), 64'd1);
    chk("midrst_tail_strobe", 64'(strobe_cnt - s0), 64'd0);
    chk("midrst_tail_cfg", 64'(cfg), 64'(RV));
    run_txn(32'h84C3_0000, 16, ds, de);
    chk("midrst_reg4", 64'(cfg[39:32]), 64'hC3);

    for (int k = 0; k < 40; k++) begin
      ra  = 7'($urandom_range(0, 11));
      w   = {1'($urandom_range(0, 3) != 0), ra, 8'($urandom), 8'($urandom), 8'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel <= 5)      nb = 16;
      else if (sel <= 7) nb = $urandom_range(1, 15);
      else if (sel == 8) nb = $urandom_range(17, 24);
      else               nb = (k % 2 == 0) ? 0 : 24;
      run_txn(w, nb, ds, de);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
